run_sequencer: RTL

Parametrised top-level run controller for the multi-core processor. It sequences instruction load, data load, execute and result unload, and arbitrates the data-memory port between the UART interface and the processor. Compared with the first-generation controller it adds optional instruction-memory reuse across runs, an execute watchdog, abort, repeated runs and an error state.

---
 rtl/run_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: top-level run controller for the multi-core processor.
// Sequences instruction load, data load, execute and result unload, and
// arbitrates the data-memory port between the UART loader and the cores.
// Adds instruction-memory reuse, an execute watchdog, abort and an error state.
module run_sequencer #(
  parameter int CORE_COUNT     = 3,
  parameter int REG_WIDTH      = 12,
  parameter int DM_ADDR_WIDTH  = 12,
  parameter int CNT_WIDTH      = 26,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int RX_END_LOC     = 7,
  parameter int TX_START_LOC   = 5,
  parameter int TX_END_LOC     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            reload_imem,
  input  logic                            abort,
  input  logic                            imem_rx_done,
  input  logic                            dmem_rx_done,
  input  logic                            proc_done,
  input  logic                            dmem_tx_done,
  input  logic [DM_ADDR_WIDTH-1:0]        uart_dm_addr,
  input  logic                            uart_dm_wr_en,
  input  logic [CORE_COUNT*REG_WIDTH-1:0] uart_dm_wdata,
  input  logic [DM_ADDR_WIDTH-1:0]        proc_dm_addr,
  input  logic                            proc_dm_wr_en,
  input  logic [CORE_COUNT*REG_WIDTH-1:0] proc_dm_wdata,
  output logic [DM_ADDR_WIDTH-1:0]        dm_addr,
  output logic                            dm_wr_en,
  output logic [CORE_COUNT*REG_WIDTH-1:0] dm_wdata,
  input  logic                            uart_im_wr_en,
  output logic                            im_wr_en,
  output logic                            im_sel_proc,
  output logic                            proc_start,
  output logic                            dmem_tx_start,
  output logic [REG_WIDTH-1:0]            rx_end_addr,
  output logic [REG_WIDTH-1:0]            tx_start_addr,
  output logic [REG_WIDTH-1:0]            tx_end_addr,
  output logic [2:0]                      state,
  output logic [1:0]                      error_code,
  output logic [CNT_WIDTH-1:0]            cycle_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_IMEM = 3'd1,
    LOAD_DMEM = 3'd2,
    EXEC      = 3'd3,
    UNLOAD    = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  localparam logic                 WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = WD_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [DM_ADDR_WIDTH-1:0] RX_END_ADDR   = DM_ADDR_WIDTH'(RX_END_LOC);
  localparam logic [DM_ADDR_WIDTH-1:0] TX_START_ADDR = DM_ADDR_WIDTH'(TX_START_LOC);
  localparam logic [DM_ADDR_WIDTH-1:0] TX_END_ADDR   = DM_ADDR_WIDTH'(TX_END_LOC);

  state_t state_q;
  logic   imem_valid;
  logic   timeout_hit;

  // The watchdog fires on the last allowed EXEC cycle; a disabled watchdog never fires.
  assign timeout_hit = WD_EN && (cycle_count == WD_LAST);

  assign state = state_q;

  // Run-control FSM with registered start pulses, error code and execute cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      imem_valid    <= 1'b0;
      proc_start    <= 1'b0;
      dmem_tx_start <= 1'b0;
      error_code    <= ERR_NONE;
      cycle_count   <= '0;
    end else begin
      proc_start    <= 1'b0;
      dmem_tx_start <= 1'b0;
      if (state_q == EXEC && cycle_count != CNT_MAX) begin
        cycle_count <= cycle_count + 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (reload_imem || !imem_valid) state_q <= LOAD_IMEM;
            else                            state_q <= LOAD_DMEM;
          end
        end
        LOAD_IMEM: begin
          if (abort) begin
            state_q    <= ERROR;
            error_code <= ERR_ABORT;
          end else if (imem_rx_done) begin
            imem_valid <= 1'b1;
            state_q    <= LOAD_DMEM;
          end
        end
        LOAD_DMEM: begin
          if (abort) begin
            state_q    <= ERROR;
            error_code <= ERR_ABORT;
          end else if (dmem_rx_done) begin
            state_q     <= EXEC;
            proc_start  <= 1'b1;
            cycle_count <= '0;
          end
        end
        EXEC: begin
          if (abort) begin
            state_q    <= ERROR;
            error_code <= ERR_ABORT;
          end else if (proc_done) begin
            state_q       <= UNLOAD;
            dmem_tx_start <= 1'b1;
          end else if (timeout_hit) begin
            state_q    <= ERROR;
            error_code <= ERR_TIMEOUT;
          end
        end
        UNLOAD: begin
          if (abort) begin
            state_q    <= ERROR;
            error_code <= ERR_ABORT;
          end else if (dmem_tx_done) begin
            state_q <= DONE;
          end
        end
        ERROR: begin
          if (start) begin
            state_q    <= IDLE;
            error_code <= ERR_NONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Latch the transfer descriptors as the UART writes them into data memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_end_addr   <= '0;
      tx_start_addr <= '0;
      tx_end_addr   <= '0;
    end else if (state_q == LOAD_DMEM && uart_dm_wr_en) begin
      if (uart_dm_addr == RX_END_ADDR)   rx_end_addr   <= uart_dm_wdata[REG_WIDTH-1:0];
      if (uart_dm_addr == TX_START_ADDR) tx_start_addr <= uart_dm_wdata[REG_WIDTH-1:0];
      if (uart_dm_addr == TX_END_ADDR)   tx_end_addr   <= uart_dm_wdata[REG_WIDTH-1:0];
    end
  end

  // Data-memory port owner: UART while loading/unloading, cores while executing, idle otherwise.
  always_comb begin
    dm_addr  = '0;
    dm_wr_en = 1'b0;
    dm_wdata = '0;
    case (state_q)
      LOAD_DMEM, UNLOAD: begin
        dm_addr  = uart_dm_addr;
        dm_wr_en = uart_dm_wr_en;
        dm_wdata = uart_dm_wdata;
      end
      EXEC: begin
        dm_addr  = proc_dm_addr;
        dm_wr_en = proc_dm_wr_en;
        dm_wdata = proc_dm_wdata;
      end
      default: ;
    endcase
  end

  assign im_wr_en    = (state_q == LOAD_IMEM) && uart_im_wr_en;
  assign im_sel_proc = (state_q == EXEC);

endmodule
